// File: rtl/control_seq_pkg.sv
// Shared typedefs for the 8-bit accumulator CPU: opcodes, sequencer phases and
// the ALU-operation membership test used by the decoder and its assertions.
package control_seq_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes whose result comes back through the ALU into the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational strobe decoder: (phase, opcode, zero, halted) -> datapath
// control strobes for one instruction phase.
module control_decode
  import control_seq_pkg::*;
(
  input  phase_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    halted,
  output logic    sel,
  output logic    rd,
  output logic    ld_ir,
  output logic    inc_pc,
  output logic    ld_pc,
  output logic    ld_ac,
  output logic    wr,
  output logic    data_e,
  output logic    halt
);

  logic aluop;
  assign aluop = is_aluop(opcode);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;

    unique case (phase)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == HLT);
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == SKZ) && zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        inc_pc = (opcode == JMP);
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
        wr     = (opcode == STO);
      end
      default: ;
    endcase

    // Once halted, only the halt indicator survives.
    if (halted) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b1;
    end
  end

endmodule

// File: rtl/control_seq.sv
// Instruction-cycle sequencer: 8-phase counter plus sticky halted flag, driving
// the combinational strobe decoder.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int unsigned PHASES = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    sel,
  output logic    rd,
  output logic    ld_ir,
  output logic    inc_pc,
  output logic    ld_pc,
  output logic    ld_ac,
  output logic    wr,
  output logic    data_e,
  output logic    halt,
  output phase_t  phase
);

  if (PHASES != 8) begin : g_phases_check
    $error("control_seq: PHASES must be 8");
  end

  phase_t phase_q;
  logic   halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else if (en && !halted_q) begin
      if (phase_q == OP_ADDR && opcode == HLT) begin
        halted_q <= 1'b1;
      end else begin
        // STORE + 1 wraps naturally to INST_ADDR in 3 bits.
        phase_q <= phase_t'(phase_q + 3'd1);
      end
    end
  end

  assign phase = phase_q;

  control_decode u_decode (
    .phase  (phase_q),
    .opcode (opcode),
    .zero   (zero),
    .halted (halted_q),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  a_wr_data_e: assert property (@(posedge clk) disable iff (rst) wr |-> data_e);
  a_wr_rd:     assert property (@(posedge clk) disable iff (rst) !(wr && rd));
  a_ld_ir:     assert property (@(posedge clk) disable iff (rst)
                                ld_ir |-> (phase_q == INST_LOAD || phase_q == IDLE));
  a_sel:       assert property (@(posedge clk) disable iff (rst)
                                sel |-> (phase_q < OP_ADDR));

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Instruction-cycle sequencer for the 8-bit accumulator CPU.
- Steps through an 8-phase fetch/execute cycle.
- Generates every datapath control strobe: memory address select, memory read/write, IR/AC/PC loads, PC increment, data bus enable and halt.
- It is the driving end of the ALU interface. It decides when ALU inputs are presented and when the ALU result is loaded into the accumulator; it consumes the ALU zero flag.

Parameters:
- PHASES, 8, number of sequencer phases per instruction; fixed at 8, present for documentation and elaboration checks only.

Ports:
- clk  input  1  system clock; all state advances on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  phase-advance enable; when low, all state holds.
- opcode  input  opcode_t  current instruction opcode from IR (shared package enum).
- zero  input  1  ALU zero flag (accumulator == 0).
- sel  output  1  1 = PC drives memory address, 0 = IR operand field.
- rd  output  1  memory read strobe.
- ld_ir  output  1  load instruction register.
- inc_pc  output  1  increment program counter.
- ld_pc  output  1  load program counter from IR operand.
- ld_ac  output  1  load accumulator from ALU out.
- wr  output  1  memory write strobe.
- data_e  output  1  drive accumulator onto data bus.
- halt  output  1  CPU halted indicator.
- phase  output  phase_t  current phase, for debug and assertions.

Behaviour:
- State: phase register (phase_t, 3-bit) plus sticky halted flag.
- Reset (rst=1 at posedge): phase=INST_ADDR, halted=0.
- After reset, every control output is 0 except sel=1.
- rst overrides en. Reset mid-instruction abandons the instruction; no partial write survives, because wr=0 in INST_ADDR.
- Advance: on posedge with en=1 and halted=0, phase moves to the next phase in order. STORE wraps to INST_ADDR.
- Phase order: INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE -> OP_ADDR -> OP_FETCH -> ALU_OP -> STORE.
- en=0: phase and halted hold; outputs stay the decode of the held phase.
- Halt: if phase==OP_ADDR and opcode==HLT at a posedge with en=1, halted is set and phase stays OP_ADDR. Only rst clears halted.
- While halted: halt=1 and every other strobe is 0.
- Output decode: combinational from (phase, opcode, zero, halted). Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
  - STORE: rd=ALUOP, ld_ac=ALUOP, inc_pc=(opcode==JMP), ld_pc=(opcode==JMP), data_e=(opcode==STO), wr=(opcode==STO).
- Any strobe not listed for a phase is 0.
- Timing contract with the ALU:
  - ALU inputs (accum, data, opcode) are stable through OP_FETCH/ALU_OP.
  - The ALU updates out on negedge inside ALU_OP.
  - ld_ac is asserted only in STORE, so the accumulator loads a settled ALU result at the STORE->INST_ADDR posedge.
- Invariants:
  - wr implies data_e.
  - ld_ir only in INST_LOAD/IDLE.
  - wr and rd never both 1.
  - sel=1 only in the first four phases.
- opcode is ignored before INST_LOAD; it is assumed stable from IDLE through STORE (IR-held).

Decomposition:
- The shared typedefs package gains phase_t (INST_ADDR=0 … STORE=7). It sits alongside the existing opcode_t.
- The ALUOP membership set is a package function is_aluop(opcode_t) so assertions reuse it.
- One natural sub-module: control_decode, a pure combinational phase/opcode/zero -> strobe decoder.
- control_seq holds the phase counter and halted flag.

Test Plan:
- Reset: assert rst 2 cycles -> phase=INST_ADDR, sel=1, all other outputs 0, halt=0.
- ADD cycle: opcode=ADD, en=1, 8 clocks -> rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in STORE; wr=0 throughout; phase wraps to INST_ADDR on clock 8.
- SKZ: opcode=SKZ, zero=1 -> inc_pc=1 in OP_ADDR and ALU_OP (two increments). Repeat with zero=0 -> inc_pc=1 only in OP_ADDR.
- STO then JMP:
  - STO -> data_e=1 in ALU_OP and STORE, wr=1 only in STORE.
  - JMP -> ld_pc=1 in ALU_OP and STORE, inc_pc=1 in OP_ADDR and STORE.
- HLT: opcode=HLT -> halt=1 from OP_ADDR onward; phase frozen for 20 clocks with all strobes 0. rst=1 -> returns to INST_ADDR, halt=0.
- Stall and mid-op reset:
  - en=0 for 3 cycles in ALU_OP -> phase and outputs held.
  - rst=1 while in STORE with opcode=STO -> next cycle phase=INST_ADDR, wr=0.
